alu_op_sequencer: RTL and testbench

Request front-end for the gate-level ALU arithmetic units: add, subtract, multiply and the 4-bit repeated-subtraction divider.
- Accepts one operation per valid/ready handshake and registers the operands so they are held stable into the combinational units.
- Waits a programmable settle time for the ripple paths, then captures the selected unit's 8-bit result with status flags.
- Presents the result on a valid/ready output.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_result_select.sv | 55 +++++
 rtl/alu_op_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request front-end.
//   OP_*    : two-bit opcode encodings seen on in_op/out_op
//   state_t : sequencer FSM encoding
//   RES_W / OPND_W : result and operand widths
package alu_pkg;

    localparam int RES_W  = 8;
    localparam int OPND_W = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_HOLD   = 2'b10
    } state_t;

endpackage

// File: rtl/alu_result_select.sv
// Combinational result selection for the ALU front-end.
// Picks the arithmetic unit output matching the opcode and derives the
// divide status flags.
//   op        : opcode of the operation in flight
//   a, b      : registered operands
//   sum_res .. quot_res : unit outputs
//   result    : selected 8-bit result
//   dz        : DIV with b == 0
//   range_err : DIV whose quotient exceeds what the divider resolves (0..4)
module alu_result_select
    import alu_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [RES_W-1:0]  sum_res,
    input  logic [RES_W-1:0]  diff_res,
    input  logic [RES_W-1:0]  prod_res,
    input  logic [RES_W-1:0]  quot_res,
    output logic [RES_W-1:0]  result,
    output logic              dz,
    output logic              range_err
);

    // 5*b peaks at 75, so 7 bits hold both sides of the range compare.
    logic [6:0] a_ext;
    logic [6:0] b_x5;
    logic       b_zero;

    assign a_ext  = {3'b000, a};
    assign b_x5   = {3'b000, b} + {1'b0, b, 2'b00};
    assign b_zero = (b == '0);

    always_comb begin
        result    = '0;
        dz        = 1'b0;
        range_err = 1'b0;
        case (op)
            OP_ADD: result = sum_res;
            OP_SUB: result = diff_res;
            OP_MUL: result = prod_res;
            OP_DIV: begin
                if (b_zero) begin
                    // Divider output is meaningless with b == 0; report zero.
                    dz = 1'b1;
                end else begin
                    result    = quot_res;
                    range_err = (a_ext >= b_x5);
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request front-end for the gate-level ALU units.
// Accepts one request per in_valid/in_ready handshake, holds the operands
// on op_a/op_b while the ripple paths settle for SETTLE_CYCLES cycles,
// then captures the selected unit result and flags and offers them on
// out_valid/out_ready.
//   clk, rst_n              : clock, async active-low reset
//   in_valid/in_ready, in_a, in_b, in_op : request side
//   op_a, op_b              : registered operands to all units
//   sum_res..quot_res       : unit results
//   out_valid/out_ready, out_result, out_op, out_dz, out_range : result side
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no operation in flight, in_ready = 1
// ST_SETTLE | operands launched, down-counter running to terminal count
// ST_HOLD   | result captured, out_valid = 1 until the consumer takes it
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic [1:0]        in_op,
    output logic [OPND_W-1:0] op_a,
    output logic [OPND_W-1:0] op_b,
    input  logic [RES_W-1:0]  sum_res,
    input  logic [RES_W-1:0]  diff_res,
    input  logic [RES_W-1:0]  prod_res,
    input  logic [RES_W-1:0]  quot_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_result,
    output logic [1:0]        out_op,
    output logic              out_dz,
    output logic              out_range
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t          state;
    logic [3:0]      cnt;
    logic [1:0]      op_q;
    logic [RES_W-1:0] sel_result;
    logic            sel_dz;
    logic            sel_range;

    alu_result_select u_sel (
        .op        (op_q),
        .a         (op_a),
        .b         (op_b),
        .sum_res   (sum_res),
        .diff_res  (diff_res),
        .prod_res  (prod_res),
        .quot_res  (quot_res),
        .result    (sel_result),
        .dz        (sel_dz),
        .range_err (sel_range)
    );

    // In HOLD the slot frees up in the same cycle the result is taken,
    // which is what allows back-to-back requests.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_IDLE:   in_ready = 1'b1;
            ST_SETTLE: in_ready = 1'b0;
            ST_HOLD:   in_ready = out_ready;
            default:   in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_q       <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_op     <= '0;
            out_dz     <= 1'b0;
            out_range  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a  <= in_a;
                        op_b  <= in_b;
                        op_q  <= in_op;
                        cnt   <= CNT_LOAD;
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == 4'd0) begin
                        out_result <= sel_result;
                        out_op     <= op_q;
                        out_dz     <= sel_dz;
                        out_range  <= sel_range;
                        out_valid  <= 1'b1;
                        state      <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            op_a  <= in_a;
                            op_b  <= in_b;
                            op_q  <= in_op;
                            cnt   <= CNT_LOAD;
                            state <= ST_SETTLE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer. The arithmetic units are modelled
// from op_a/op_b; the divider output is a bench-controlled value so the
// pass-through and forcing rules can be seen directly.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_op;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [7:0] sum_res;
    logic [7:0] diff_res;
    logic [7:0] prod_res;
    logic [7:0] quot_res;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [1:0] out_op;
    logic       out_dz;
    logic       out_range;
    logic [7:0] quot_drive;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign sum_res  = {4'b0000, op_a} + {4'b0000, op_b};
    assign diff_res = {4'b0000, op_a} - {4'b0000, op_b};
    assign prod_res = {4'b0000, op_a} * {4'b0000, op_b};
    assign quot_res = quot_drive;

    alu_op_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .sum_res    (sum_res),
        .diff_res   (diff_res),
        .prod_res   (prod_res),
        .quot_res   (quot_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_dz     (out_dz),
        .out_range  (out_range)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [7:0] res, input logic [1:0] op,
                           input logic dz, input logic rng);
        chk({tag, " result"}, out_result, res);
        chk({tag, " op"}, {6'b0, out_op}, {6'b0, op});
        chk({tag, " dz"}, {7'b0, out_dz}, {7'b0, dz});
        chk({tag, " range"}, {7'b0, out_range}, {7'b0, rng});
    endtask

    // Issue one request from IDLE and check exact latency to out_valid.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        chk({tag, " idle ready"}, {7'b0, in_ready}, 8'h01);
        step();
        in_valid = 1'b0;
        chk({tag, " op_a"}, {4'b0, op_a}, {4'b0, a});
        chk({tag, " op_b"}, {4'b0, op_b}, {4'b0, b});
        chk({tag, " settle ready"}, {7'b0, in_ready}, 8'h00);
        chk({tag, " valid at accept"}, {7'b0, out_valid}, 8'h00);
        for (int i = 1; i < S; i++) begin
            step();
            chk({tag, " valid early"}, {7'b0, out_valid}, 8'h00);
        end
        step();
        chk({tag, " valid latency"}, {7'b0, out_valid}, 8'h01);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " valid drop"}, {7'b0, out_valid}, 8'h00);
        chk({tag, " back to idle"}, {7'b0, in_ready}, 8'h01);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        out_ready = 1'b0; quot_drive = 8'h00;
        #3;
        chk("rst in_ready", {7'b0, in_ready}, 8'h01);
        chk("rst out_valid", {7'b0, out_valid}, 8'h00);
        chk("rst op_a", {4'b0, op_a}, 8'h00);
        chk("rst out_result", out_result, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ADD 3+5 with consumer always ready
        out_ready = 1'b1;
        run_op("add", OP_ADD, 4'd3, 4'd5);
        chk_res("add", 8'h08, OP_ADD, 1'b0, 1'b0);
        handshake("add");

        // DIV inside the divider range
        quot_drive = 8'h04;
        run_op("div9_2", OP_DIV, 4'd9, 4'd2);
        chk_res("div9_2", 8'h04, OP_DIV, 1'b0, 1'b0);
        handshake("div9_2");

        // DIV quotient beyond divider range: flag, pass quotient through
        quot_drive = 8'hA5;
        run_op("div15_1", OP_DIV, 4'd15, 4'd1);
        chk_res("div15_1", 8'hA5, OP_DIV, 1'b0, 1'b1);
        handshake("div15_1");

        // DIV at the exact range boundary (10 >= 5*2)
        quot_drive = 8'h05;
        run_op("div10_2", OP_DIV, 4'd10, 4'd2);
        chk_res("div10_2", 8'h05, OP_DIV, 1'b0, 1'b1);
        handshake("div10_2");

        // DIV by zero: result forced to zero regardless of divider output
        quot_drive = 8'h3C;
        run_op("div7_0", OP_DIV, 4'd7, 4'd0);
        chk_res("div7_0", 8'h00, OP_DIV, 1'b1, 1'b0);
        handshake("div7_0");

        // MUL 15*15 held under backpressure
        run_op("mul", OP_MUL, 4'd15, 4'd15);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mul hold valid", {7'b0, out_valid}, 8'h01);
            chk("mul hold result", out_result, 8'hE1);
            chk("mul hold ready", {7'b0, in_ready}, 8'h00);
            chk("mul hold op_a", {4'b0, op_a}, 8'h0F);
        end
        out_ready = 1'b1;
        #1;
        chk("mul ready follows", {7'b0, in_ready}, 8'h01);
        step();
        out_ready = 1'b0;
        chk("mul valid drop", {7'b0, out_valid}, 8'h00);
        chk("mul idle", {7'b0, in_ready}, 8'h01);
        chk("mul result kept", out_result, 8'hE1);

        // Back-to-back: SUB 9-4 then ADD 1+1
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = OP_SUB; in_a = 4'd9; in_b = 4'd4;
        step();
        in_op = OP_ADD; in_a = 4'd1; in_b = 4'd1;
        chk("b2b sub op_a", {4'b0, op_a}, 8'h09);
        step();
        chk("b2b sub early", {7'b0, out_valid}, 8'h00);
        chk("b2b no early accept", {4'b0, op_a}, 8'h09);
        step();
        chk("b2b sub valid", {7'b0, out_valid}, 8'h01);
        chk_res("b2b sub", 8'h05, OP_SUB, 1'b0, 1'b0);
        chk("b2b hold ready", {7'b0, in_ready}, 8'h01);
        step();
        in_valid = 1'b0;
        chk("b2b valid drop", {7'b0, out_valid}, 8'h00);
        chk("b2b add op_a", {4'b0, op_a}, 8'h01);
        chk("b2b add settle", {7'b0, in_ready}, 8'h00);
        step();
        chk("b2b add early", {7'b0, out_valid}, 8'h00);
        step();
        chk("b2b add valid", {7'b0, out_valid}, 8'h01);
        chk_res("b2b add", 8'h02, OP_ADD, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        chk("b2b idle", {7'b0, out_valid}, 8'h00);

        // Reset in the middle of SETTLE
        in_valid = 1'b1; in_op = OP_SUB; in_a = 4'd7; in_b = 4'd3;
        step();
        in_valid = 1'b0;
        chk("mid op_a launched", {4'b0, op_a}, 8'h07);
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", {7'b0, out_valid}, 8'h00);
        chk("mid rst op_a", {4'b0, op_a}, 8'h00);
        chk("mid rst op_b", {4'b0, op_b}, 8'h00);
        chk("mid rst in_ready", {7'b0, in_ready}, 8'h01);
        chk("mid rst result", out_result, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post rst no valid", {7'b0, out_valid}, 8'h00);
        run_op("add2_2", OP_ADD, 4'd2, 4'd2);
        chk_res("add2_2", 8'h04, OP_ADD, 1'b0, 1'b0);
        handshake("add2_2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
